// File: rtl/cue_aim_controller_pkg.sv
// Shared types and constants for the cue aim controller and its direction ROM.
package billiard_pkg;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FP_SHIFT               = 6;

  typedef logic signed [10:0] coord_t;
  typedef logic [5:0]         angle_t;
  typedef logic signed [7:0]  trig_t;

  typedef enum logic [1:0] {AIM, CHARGE, FIRE, ROLLING} aim_state_t;

  // sin(k * pi/32) * 64, rounded, for k = 0..16
  function automatic trig_t quarter_sin(input logic [4:0] k);
    trig_t v;
    case (k)
      5'd0:    v = 8'sd0;
      5'd1:    v = 8'sd6;
      5'd2:    v = 8'sd12;
      5'd3:    v = 8'sd19;
      5'd4:    v = 8'sd24;
      5'd5:    v = 8'sd30;
      5'd6:    v = 8'sd36;
      5'd7:    v = 8'sd41;
      5'd8:    v = 8'sd45;
      5'd9:    v = 8'sd49;
      5'd10:   v = 8'sd53;
      5'd11:   v = 8'sd56;
      5'd12:   v = 8'sd59;
      5'd13:   v = 8'sd61;
      5'd14:   v = 8'sd63;
      5'd15:   v = 8'sd64;
      default: v = 8'sd64;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cue_aim_controller_if.sv
// Shot handoff from the aim controller to ball physics (valid/ready transfer).
interface cue_aim_controller_if;
  import billiard_pkg::*;

  logic   shotValid;
  logic   shotReady;
  coord_t shotVelX;
  coord_t shotVelY;

  modport master (output shotValid, shotVelX, shotVelY, input shotReady);
  modport slave  (input shotValid, shotVelX, shotVelY, output shotReady);
endinterface

// File: rtl/cue_aim_controller_aim_direction_lut.sv
// Registered 64-entry direction ROM: angle -> (cos, sin) scaled by 64, built from a quarter wave.
module aim_direction_lut
  import billiard_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  angle_t angle,
  output trig_t  cos_q,
  output trig_t  sin_q
);

  function automatic trig_t sin_of(input angle_t a);
    logic [4:0] i;
    logic [4:0] mirror;
    i      = {1'b0, a[3:0]};
    mirror = 5'd16 - i;
    case (a[5:4])
      2'd0:    return  quarter_sin(i);
      2'd1:    return  quarter_sin(mirror);
      2'd2:    return -quarter_sin(i);
      default: return -quarter_sin(mirror);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cos_q <= sin_of(angle + 6'd16);
      sin_q <= sin_of(angle);
    end
  end

endmodule

// File: rtl/cue_aim_controller.sv
// Cue shot sequencer: aim rotation, power charge, shot handoff, settle wait.
// Optional: define POWER_PINGPONG_EN to make the charge ramp up and down instead of saturating.
module cue_aim_controller
  import billiard_pkg::*;
#(
  parameter int unsigned BALL_RADIUS   = 8,
  parameter int unsigned LINE_LENGTH   = 64,
  parameter int unsigned ROT_DIV       = 4,
  parameter int unsigned POWER_STEP    = 2,
  parameter int unsigned MAX_POWER     = 127,
  parameter int unsigned SETTLE_FRAMES = 8
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startOfFrame,
  input  coord_t                ballTopLeftX,
  input  coord_t                ballTopLeftY,
  input  logic                  keyLeft,
  input  logic                  keyRight,
  input  logic                  keyEnter,
  input  logic                  ballsMoving,
  output coord_t                lineEndX,
  output coord_t                lineEndY,
  output logic                  drawLineEnable,
  output logic [6:0]            aimPower,
  cue_aim_controller_if.master  shot
);

  localparam logic [7:0]         ROT_LAST = 8'(ROT_DIV - 1);
  localparam logic [7:0]         SETTLE   = 8'(SETTLE_FRAMES);
  localparam logic [7:0]         STEP     = 8'(POWER_STEP);
  localparam logic [7:0]         PMAX     = 8'(MAX_POWER);
  localparam logic signed [18:0] LINE_LEN = 19'(LINE_LENGTH);
  localparam coord_t             RADIUS   = 11'(BALL_RADIUS);

  aim_state_t state, state_next;
  angle_t     angle, angle_next;
  logic [6:0] power, power_next;
  logic [7:0] rot_cnt, rot_next, still_cnt, still_next, power_sum;
  logic       enter_prev, ramp_down, down_next;
  coord_t     vel_x, vel_y, vel_x_next, vel_y_next, centre_x, centre_y;
  trig_t      cos_q, sin_q;
  logic signed [15:0] vel_x_prod, vel_y_prod;
  logic signed [18:0] line_x_prod, line_y_prod;

  aim_direction_lut lut (
    .clk   (clk),
    .reset (reset),
    .angle (angle),
    .cos_q (cos_q),
    .sin_q (sin_q)
  );

  assign power_sum   = {1'b0, power} + STEP;
  assign vel_x_prod  = 16'(cos_q) * $signed({9'b0, power});
  assign vel_y_prod  = 16'(sin_q) * $signed({9'b0, power});
  assign line_x_prod = 19'(cos_q) * LINE_LEN;
  assign line_y_prod = 19'(sin_q) * LINE_LEN;

  assign aimPower       = power;
  assign shot.shotValid = (state == FIRE);
  assign shot.shotVelX  = vel_x;
  assign shot.shotVelY  = vel_y;

  always_comb begin
    state_next = state;
    angle_next = angle;
    power_next = power;
    rot_next   = rot_cnt;
    still_next = still_cnt;
    down_next  = ramp_down;
    vel_x_next = vel_x;
    vel_y_next = vel_y;
    case (state)
      AIM: begin
        if (startOfFrame) begin
          if (keyLeft ^ keyRight) begin
            if (rot_cnt == ROT_LAST) begin
              rot_next   = '0;
              angle_next = keyRight ? angle + 6'd1 : angle - 6'd1;
            end else begin
              rot_next = rot_cnt + 8'd1;
            end
          end else begin
            rot_next = '0;
          end
        end
        if (keyEnter && !enter_prev) begin
          state_next = CHARGE;
          power_next = '0;
          down_next  = 1'b0;
        end
      end
      CHARGE: begin
        // Release wins over a coincident frame tick: the shot uses the power shown so far.
        if (!keyEnter) begin
          state_next = FIRE;
          vel_x_next = 11'(vel_x_prod >>> FP_SHIFT);
          vel_y_next = 11'(vel_y_prod >>> FP_SHIFT);
        end else if (startOfFrame) begin
`ifdef POWER_PINGPONG_EN
          if (!ramp_down) begin
            if (power_sum >= PMAX) begin
              power_next = 7'(PMAX);
              down_next  = 1'b1;
            end else begin
              power_next = 7'(power_sum);
            end
          end else begin
            if ({1'b0, power} <= STEP) begin
              power_next = '0;
              down_next  = 1'b0;
            end else begin
              power_next = power - 7'(STEP);
            end
          end
`else
          power_next = (power_sum > PMAX) ? 7'(PMAX) : 7'(power_sum);
`endif
        end
      end
      FIRE: begin
        if (shot.shotReady) begin
          state_next = ROLLING;
          still_next = '0;
        end
      end
      default: begin
        if (still_cnt == SETTLE) begin
          state_next = AIM;
          power_next = '0;
          still_next = '0;
        end else if (ballsMoving) begin
          still_next = '0;
        end else if (startOfFrame) begin
          still_next = still_cnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= AIM;
      angle          <= '0;
      power          <= '0;
      rot_cnt        <= '0;
      still_cnt      <= '0;
      enter_prev     <= 1'b0;
      ramp_down      <= 1'b0;
      vel_x          <= '0;
      vel_y          <= '0;
      centre_x       <= '0;
      centre_y       <= '0;
      lineEndX       <= '0;
      lineEndY       <= '0;
      drawLineEnable <= 1'b0;
    end else begin
      state          <= state_next;
      angle          <= angle_next;
      power          <= power_next;
      rot_cnt        <= rot_next;
      still_cnt      <= still_next;
      enter_prev     <= keyEnter;
      ramp_down      <= down_next;
      vel_x          <= vel_x_next;
      vel_y          <= vel_y_next;
      // Centre is registered alongside the ROM so position and direction line up in the sum stage.
      centre_x       <= ballTopLeftX + RADIUS;
      centre_y       <= ballTopLeftY + RADIUS;
      lineEndX       <= centre_x + 11'(line_x_prod >>> FP_SHIFT);
      lineEndY       <= centre_y + 11'(line_y_prod >>> FP_SHIFT);
      drawLineEnable <= (state == AIM) || (state == CHARGE);
    end
  end

endmodule

// File: tb/tb_cue_aim_controller.sv
// Directed bench for cue_aim_controller; expected values are hand-computed (ball at 100,200).
module tb_cue_aim_controller;
  import billiard_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sof = 1'b0;
  coord_t     bx = 11'sd100;
  coord_t     by = 11'sd200;
  logic       kl = 1'b0, kr = 1'b0, ke = 1'b0, bm = 1'b0;
  coord_t     lx, ly;
  logic       dle;
  logic [6:0] ap;
  int         compared = 0;
  int         mismatched = 0;

  cue_aim_controller_if shot_bus();

  cue_aim_controller #(
    .BALL_RADIUS(8), .LINE_LENGTH(64), .ROT_DIV(4),
    .POWER_STEP(2), .MAX_POWER(127), .SETTLE_FRAMES(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (sof),
    .ballTopLeftX   (bx),
    .ballTopLeftY   (by),
    .keyLeft        (kl),
    .keyRight       (kr),
    .keyEnter       (ke),
    .ballsMoving    (bm),
    .lineEndX       (lx),
    .lineEndY       (ly),
    .drawLineEnable (dle),
    .aimPower       (ap),
    .shot           (shot_bus)
  );

  always #5 clk = ~clk;

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1'b1;
      @(negedge clk);
      sof = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (lx !== 11'sd0) begin mismatched++; $display("FAIL reset_lineEndX got %0d expected 0", lx); end
    compared++; if (dle !== 1'b0) begin mismatched++; $display("FAIL reset_drawLineEnable got %0b expected 0", dle); end
    compared++; if (ap !== 7'd0) begin mismatched++; $display("FAIL reset_aimPower got %0d expected 0", ap); end
    compared++; if (shot_bus.shotValid !== 1'b0) begin mismatched++; $display("FAIL reset_shotValid got %0b expected 0", shot_bus.shotValid); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (lx !== 11'sd172) begin mismatched++; $display("FAIL angle0_lineEndX got %0d expected 172", lx); end
    compared++; if (ly !== 11'sd208) begin mismatched++; $display("FAIL angle0_lineEndY got %0d expected 208", ly); end
    compared++; if (dle !== 1'b1) begin mismatched++; $display("FAIL aim_drawLineEnable got %0b expected 1", dle); end
    compared++; if (shot_bus.shotValid !== 1'b0) begin mismatched++; $display("FAIL aim_shotValid got %0b expected 0", shot_bus.shotValid); end
  endtask

  task automatic test_rotate;
    kr = 1'b1; frames(64); kr = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (lx !== 11'sd108) begin mismatched++; $display("FAIL angle16_lineEndX got %0d expected 108", lx); end
    compared++; if (ly !== 11'sd272) begin mismatched++; $display("FAIL angle16_lineEndY got %0d expected 272", ly); end
    kl = 1'b1; kr = 1'b1; frames(8); kl = 1'b0; kr = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (lx !== 11'sd108) begin mismatched++; $display("FAIL both_keys_lineEndX got %0d expected 108", lx); end
    compared++; if (ly !== 11'sd272) begin mismatched++; $display("FAIL both_keys_lineEndY got %0d expected 272", ly); end
    kl = 1'b1; frames(64); kl = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (ly !== 11'sd208) begin mismatched++; $display("FAIL back_to_0_lineEndY got %0d expected 208", ly); end
    kl = 1'b1; frames(4); kl = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (lx !== 11'sd172) begin mismatched++; $display("FAIL wrap63_lineEndX got %0d expected 172", lx); end
    compared++; if (ly !== 11'sd202) begin mismatched++; $display("FAIL wrap63_lineEndY got %0d expected 202", ly); end
    kr = 1'b1; frames(4); kr = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (ly !== 11'sd208) begin mismatched++; $display("FAIL wrap0_lineEndY got %0d expected 208", ly); end
  endtask

  task automatic test_charge_fire;
    ke = 1'b1;
    @(negedge clk);
    frames(10);
    compared++; if (ap !== 7'd20) begin mismatched++; $display("FAIL charge_aimPower got %0d expected 20", ap); end
    compared++; if (shot_bus.shotValid !== 1'b0) begin mismatched++; $display("FAIL charge_shotValid got %0b expected 0", shot_bus.shotValid); end
    ke = 1'b0;
    @(negedge clk);
    compared++; if (shot_bus.shotValid !== 1'b1) begin mismatched++; $display("FAIL fire_shotValid got %0b expected 1", shot_bus.shotValid); end
    compared++; if (shot_bus.shotVelX !== 11'sd20) begin mismatched++; $display("FAIL fire_shotVelX got %0d expected 20", shot_bus.shotVelX); end
    compared++; if (shot_bus.shotVelY !== 11'sd0) begin mismatched++; $display("FAIL fire_shotVelY got %0d expected 0", shot_bus.shotVelY); end
    repeat (5) @(negedge clk);
    compared++; if (shot_bus.shotValid !== 1'b1) begin mismatched++; $display("FAIL fire_hold_shotValid got %0b expected 1", shot_bus.shotValid); end
    compared++; if (shot_bus.shotVelX !== 11'sd20) begin mismatched++; $display("FAIL fire_hold_shotVelX got %0d expected 20", shot_bus.shotVelX); end
    compared++; if (dle !== 1'b0) begin mismatched++; $display("FAIL fire_drawLineEnable got %0b expected 0", dle); end
    shot_bus.shotReady = 1'b1;
    @(negedge clk);
    shot_bus.shotReady = 1'b0;
    compared++; if (shot_bus.shotValid !== 1'b0) begin mismatched++; $display("FAIL transfer_shotValid got %0b expected 0", shot_bus.shotValid); end
  endtask

  task automatic test_rolling;
    bm = 1'b1; frames(3);
    bm = 1'b0; frames(4);
    bm = 1'b1; frames(1);
    bm = 1'b0; frames(7);
    compared++; if (dle !== 1'b0) begin mismatched++; $display("FAIL rolling_7still_drawLineEnable got %0b expected 0", dle); end
    frames(1);
    repeat (2) @(negedge clk);
    compared++; if (dle !== 1'b1) begin mismatched++; $display("FAIL settled_drawLineEnable got %0b expected 1", dle); end
    compared++; if (ap !== 7'd0) begin mismatched++; $display("FAIL settled_aimPower got %0d expected 0", ap); end
  endtask

  task automatic test_zero_power;
    ke = 1'b1;
    @(negedge clk);
    ke = 1'b0;
    @(negedge clk);
    compared++; if (shot_bus.shotValid !== 1'b1) begin mismatched++; $display("FAIL zero_shotValid got %0b expected 1", shot_bus.shotValid); end
    compared++; if (shot_bus.shotVelX !== 11'sd0) begin mismatched++; $display("FAIL zero_shotVelX got %0d expected 0", shot_bus.shotVelX); end
    shot_bus.shotReady = 1'b1;
    @(negedge clk);
    shot_bus.shotReady = 1'b0;
    frames(8);
    repeat (2) @(negedge clk);
    compared++; if (dle !== 1'b1) begin mismatched++; $display("FAIL zero_settled_drawLineEnable got %0b expected 1", dle); end
  endtask

  task automatic test_saturate_reset;
    int exp_end;
    exp_end = 127;
`ifdef POWER_PINGPONG_EN
    exp_end = 55;
`endif
    kr = 1'b1; frames(64); kr = 1'b0;
    ke = 1'b1;
    @(negedge clk);
    frames(63);
    compared++; if (ap !== 7'd126) begin mismatched++; $display("FAIL ramp63_aimPower got %0d expected 126", ap); end
    frames(1);
    compared++; if (ap !== 7'd127) begin mismatched++; $display("FAIL ramp64_aimPower got %0d expected 127", ap); end
    frames(36);
    compared++; if (ap !== 7'(exp_end)) begin mismatched++; $display("FAIL ramp100_aimPower got %0d expected %0d", ap, exp_end); end
    ke = 1'b0;
    @(negedge clk);
    compared++; if (shot_bus.shotVelX !== 11'sd0) begin mismatched++; $display("FAIL angle16_shotVelX got %0d expected 0", shot_bus.shotVelX); end
    compared++; if (shot_bus.shotVelY !== 11'(exp_end)) begin mismatched++; $display("FAIL angle16_shotVelY got %0d expected %0d", shot_bus.shotVelY, exp_end); end
    reset = 1'b1;
    @(negedge clk);
    compared++; if (shot_bus.shotValid !== 1'b0) begin mismatched++; $display("FAIL reset_fire_shotValid got %0b expected 0", shot_bus.shotValid); end
    compared++; if (ap !== 7'd0) begin mismatched++; $display("FAIL reset_fire_aimPower got %0d expected 0", ap); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (lx !== 11'sd172) begin mismatched++; $display("FAIL reset_fire_lineEndX got %0d expected 172", lx); end
    compared++; if (ly !== 11'sd208) begin mismatched++; $display("FAIL reset_fire_lineEndY got %0d expected 208", ly); end
    compared++; if (dle !== 1'b1) begin mismatched++; $display("FAIL reset_fire_drawLineEnable got %0b expected 1", dle); end
    compared++; if (shot_bus.shotValid !== 1'b0) begin mismatched++; $display("FAIL reset_fire_no_shot got %0b expected 0", shot_bus.shotValid); end
  endtask

  initial begin
    shot_bus.shotReady = 1'b0;
    test_reset();
    test_rotate();
    test_charge_fire();
    test_rolling();
    test_zero_power();
    test_saturate_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
